// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the dot-product engine.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold the sum of nterms signed k*n products without wrap.
  // The k+n product width already carries its own sign bit, so the growth
  // term is clog2(nterms) and the default 20-bit build is exactly sized.
  function automatic int min_acc_width(input int k, input int n, input int nterms);
    return k + n + $clog2(nterms);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: res = activation*weight + prev_res.
module MAC_unit #(
  parameter int n         = 8,
  parameter int b         = 8,
  parameter int k         = 8,
  parameter int res_width = 20
) (
  input  logic signed [k-1:0]         activation,
  input  logic signed [n-1:0]         weight,
  input  logic signed [res_width-1:0] prev_res,
  output logic signed [res_width-1:0] res
);

  logic signed [k+n-1:0] prod;

  if (res_width < k + n || res_width < b) begin : g_width_check
    $error("MAC_unit: res_width too small for product or bias");
  end

  assign prod = (k+n)'(activation) * (k+n)'(weight);
  assign res  = prev_res + res_width'(prod);

endmodule

// File: rtl/mac_dot_product.sv
// Sequential dot-product engine: bias load, N_TERMS streamed pairs folded
// through MAC_unit into a registered accumulator, one result per run.
//
// state | meaning
// IDLE  | waiting for a bias; bias_ready high
// ACCUM | accepting (activation, weight) pairs; in_ready high
// DONE  | result presented with out_valid until out_ready
module mac_dot_product
  import mac_pkg::*;
#(
  parameter int n         = 8,
  parameter int b         = 8,
  parameter int k         = 8,
  parameter int N_TERMS   = 16,
  parameter int acc_width = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bias_valid,
  output logic                        bias_ready,
  input  logic signed [b-1:0]         bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [k-1:0]         activation,
  input  logic signed [n-1:0]         weight,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [acc_width-1:0] result,
  output logic                        busy
);

  localparam int cnt_w = $clog2(N_TERMS + 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(N_TERMS - 1);

  if (N_TERMS < 1 || acc_width < min_acc_width(k, n, N_TERMS) || acc_width < b) begin : g_param_check
    $error("mac_dot_product: N_TERMS must be >= 1 and acc_width wide enough");
  end

  state_t                      state, state_nxt;
  logic signed [acc_width-1:0] acc, acc_nxt, mac_res, bias_ext;
  logic [cnt_w-1:0]            cnt, cnt_nxt;

  MAC_unit #(
    .n         (n),
    .b         (b),
    .k         (k),
    .res_width (acc_width)
  ) u_mac (
    .activation (activation),
    .weight     (weight),
    .prev_res   (acc),
    .res        (mac_res)
  );

  assign bias_ext = acc_width'(bias);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Ready signals are constant within a state, so a handshake reduces to valid.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bias_valid) begin
          acc_nxt   = bias_ext;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = mac_res;
          cnt_nxt = cnt + 1'b1;
          if (cnt == last_cnt) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bias_ready = (state == IDLE);
  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign result     = acc;

endmodule

// File: tb/tb_mac_dot_product.sv
// Bench for mac_dot_product: table of 4-term runs with a result scoreboard,
// plus 16-term extreme runs, backpressure, protocol and mid-run reset.
module tb_mac_dot_product;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_TERMS = 4
  logic               a_bias_valid, a_bias_ready, a_in_valid, a_in_ready;
  logic               a_out_valid, a_out_ready, a_busy;
  logic signed [7:0]  a_bias, a_activation, a_weight;
  logic signed [19:0] a_result;

  // Instance B: N_TERMS = 16
  logic               b_bias_valid, b_bias_ready, b_in_valid, b_in_ready;
  logic               b_out_valid, b_out_ready, b_busy;
  logic signed [7:0]  b_bias, b_activation, b_weight;
  logic signed [19:0] b_result;

  mac_dot_product #(.N_TERMS(4)) u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .bias_valid (a_bias_valid), .bias_ready (a_bias_ready), .bias (a_bias),
    .in_valid (a_in_valid), .in_ready (a_in_ready),
    .activation (a_activation), .weight (a_weight),
    .out_valid (a_out_valid), .out_ready (a_out_ready),
    .result (a_result), .busy (a_busy)
  );

  mac_dot_product #(.N_TERMS(16)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .bias_valid (b_bias_valid), .bias_ready (b_bias_ready), .bias (b_bias),
    .in_valid (b_in_valid), .in_ready (b_in_ready),
    .activation (b_activation), .weight (b_weight),
    .out_valid (b_out_valid), .out_ready (b_out_ready),
    .result (b_result), .busy (b_busy)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_q[$];
  int last_res = 0;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic signed [7:0] bias;
    logic [3:0][7:0]   act;
    logic [3:0][7:0]   wt;
    bit                bubbles;
    bit                protocol;
    bit                hold_out;
    int                exp;
  } vec_t;

  function automatic vec_t mk(input int bias_i,
                              input int a0, input int w0, input int a1, input int w1,
                              input int a2, input int w2, input int a3, input int w3,
                              input bit bub, input bit prot, input bit hold, input int exp_i);
    vec_t v;
    v.bias = 8'(bias_i);
    v.act[0] = 8'(a0); v.wt[0] = 8'(w0);
    v.act[1] = 8'(a1); v.wt[1] = 8'(w1);
    v.act[2] = 8'(a2); v.wt[2] = 8'(w2);
    v.act[3] = 8'(a3); v.wt[3] = 8'(w3);
    v.bubbles = bub; v.protocol = prot; v.hold_out = hold;
    v.exp = exp_i;
    return v;
  endfunction

  // Scoreboard: every accepted result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_output", 1, 0);
      else check("sb_result", longint'(a_result), longint'(exp_q.pop_front()));
    end
  end

  task automatic run_vec(input vec_t v);
    int part;
    int gap;
    int t;
    bit ok;
    if (v.protocol) begin
      a_in_valid = 1'b1; a_activation = 8'sd9; a_weight = 8'sd9;
      repeat (3) begin
        @(posedge clk); #1;
        check("idle_in_valid_busy", a_busy, 0);
        check("idle_in_valid_result", longint'(a_result), last_res);
      end
      a_in_valid = 1'b0;
    end
    a_bias_valid = 1'b1; a_bias = v.bias;
    exp_q.push_back(v.exp);
    @(posedge clk); #1;
    a_bias_valid = v.protocol;
    a_bias = 8'sd99;
    check("bias_load", longint'(a_result), longint'(v.bias));
    check("accum_in_ready", a_in_ready, 1);
    part = v.bias;
    for (int i = 0; i < 4; i++) begin
      if (v.bubbles) begin
        gap = $urandom_range(1, 3);
        a_in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #1;
          check("bubble_hold", longint'(a_result), part);
        end
      end
      a_in_valid = 1'b1; a_activation = v.act[i]; a_weight = v.wt[i];
      @(posedge clk); #1;
      part += $signed(v.act[i]) * $signed(v.wt[i]);
      if (v.bubbles) check("partial_sum", longint'(a_result), part);
    end
    a_in_valid = 1'b0; a_bias_valid = 1'b0;
    check("out_valid_latency", a_out_valid, 1);
    check("done_in_ready", a_in_ready, 0);
    if (v.hold_out) begin
      repeat (20) begin
        a_bias_valid = 1'b1; a_bias = 8'sd77;
        a_in_valid = 1'($urandom_range(0, 1)); a_activation = 8'sd50; a_weight = 8'sd50;
        @(posedge clk); #1;
        ok = a_out_valid && !a_in_ready && !a_bias_ready && (int'(a_result) == v.exp);
        check("backpressure_hold", ok, 1);
      end
      a_bias_valid = 1'b0; a_in_valid = 1'b0;
    end
    a_out_ready = 1'b1;
    t = 0;
    while (!a_out_valid && t < 10) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("idle_after_out_busy", a_busy, 0);
    check("idle_after_out_bias_ready", a_bias_ready, 1);
    check("result_retained", longint'(a_result), v.exp);
    last_res = v.exp;
  endtask

  task automatic run16(input int bias_i, input int act_i, input int wt_i, input int exp_i);
    int t;
    b_bias_valid = 1'b1; b_bias = 8'(bias_i);
    @(posedge clk); #1;
    b_bias_valid = 1'b0;
    b_in_valid = 1'b1; b_activation = 8'(act_i); b_weight = 8'(wt_i);
    repeat (16) begin @(posedge clk); #1; end
    b_in_valid = 1'b0;
    t = 0;
    while (!b_out_valid && t < 5) begin
      @(posedge clk); #1; t++;
    end
    check("b_out_valid", b_out_valid, 1);
    check("b_latency", t, 0);
    check("b_result", longint'(b_result), exp_i);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("b_idle_busy", b_busy, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = mk(5,    1, 1,     2, 3,     -4, 2,   7, -1,    0, 0, 0, -3);
    vecs[1] = mk(0,    1, 1,     2, 1,      3, 1,   4, 1,     1, 0, 0, 10);
    vecs[2] = mk(-7, -128, 127, 127, -128, -1, -1, 100, 5,    0, 1, 0, -32018);
    vecs[3] = mk(127, -128, -128, -128, -128, -128, -128, -128, -128, 0, 0, 1, 65663);
    vecs[4] = mk(-128, -128, 127, -128, 127, -128, 127, -128, 127, 1, 0, 0, -65152);

    a_bias_valid = 0; a_in_valid = 0; a_out_ready = 0;
    a_bias = '0; a_activation = '0; a_weight = '0;
    b_bias_valid = 0; b_in_valid = 0; b_out_ready = 0;
    b_bias = '0; b_activation = '0; b_weight = '0;

    #12;
    check("rst_bias_ready", a_bias_ready, 1);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_result", longint'(a_result), 0);
    check("rst_busy", a_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    run16(127, -128, -128, 262271);
    run16(-128, -128, 127, -260224);

    // Reset in the middle of a run: partial sum dropped, nothing emitted.
    a_bias_valid = 1'b1; a_bias = 8'sd5;
    @(posedge clk); #1;
    a_bias_valid = 1'b0;
    a_in_valid = 1'b1; a_activation = 8'sd1; a_weight = 8'sd2;
    @(posedge clk); #1;
    a_activation = 8'sd3; a_weight = 8'sd4;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("mid_partial", longint'(a_result), 19);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bias_ready", a_bias_ready, 1);
    check("mid_rst_in_ready", a_in_ready, 0);
    check("mid_rst_out_valid", a_out_valid, 0);
    check("mid_rst_result", longint'(a_result), 0);
    check("mid_rst_busy", a_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_res = 0;
    run_vec(mk(0, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 36));

    repeat (2) @(posedge clk);
    check("sb_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
